seq_shift_unit: RTL

//  Multi-cycle logical shifter, the sequential stage that feeds the 4-bit logical_shifts datapath.
//  It captures an operand, a shift amount and a direction, then applies one 1-bit logical shift
//  per clock (zero fill).
//  It signals completion with a one-cycle done pulse and holds the result on dout.

---
 rtl/seq_shift_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/seq_shift_unit.sv
// Multi-cycle logical shifter: one 1-bit zero-fill shift per clock, then a one-cycle done pulse.
// The result is held on dout until the next completion.
module seq_shift_unit #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             dir,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] din,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dout
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [WIDTH-1:0] shifted;
   logic [AMT_W-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             done_q, done_d;
   logic             last;

   function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic right);
      return right ? {1'b0, v[WIDTH-1:1]} : {v[WIDTH-2:0], 1'b0};
   endfunction

   assign shifted = shift1(data_q, dir_q);
   assign last    = (count_q == AMT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         dout_q  <= '0;
         count_q <= '0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         dout_q  <= dout_d;
         count_q <= count_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && (amt != '0)) state_d = SHIFT;
         SHIFT:   if (last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A zero amount completes straight from IDLE without entering SHIFT.
   always_comb begin
      data_d  = data_q;
      dout_d  = dout_q;
      count_d = count_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (amt == '0) begin
                  dout_d = din;
                  done_d = 1'b1;
               end else begin
                  data_d  = din;
                  count_d = amt;
                  dir_d   = dir;
               end
            end
         end
         SHIFT: begin
            data_d  = shifted;
            count_d = count_q - AMT_W'(1);
            if (last) begin
               dout_d = shifted;
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy = (state_q == SHIFT);
      done = done_q;
      dout = dout_q;
   end

endmodule
